// File: rtl/ysyx_22041752_refill_pkg.sv
// Shared definitions for the cache-line refill sequencer: AXI burst encodings,
// refill FSM state encodings, SRAM macro geometry and the beat placement helper.
package ysyx_22041752_refill_pkg;

    localparam logic [1:0] BURST_INCR    = 2'b01;
    localparam logic [1:0] BURST_WRAP    = 2'b10;

    localparam int         SRAM_INDEX_WD = 6;
    localparam int         LINE_WD       = 128;
    localparam int         BEAT_WD       = 64;

    typedef enum logic [2:0] {
        REFILL_IDLE = 3'd0,
        REFILL_AR   = 3'd1,
        REFILL_R    = 3'd2,
        REFILL_WR   = 3'd3,
        REFILL_RESP = 3'd4
    } refill_state_e;

    // Line half that the current beat lands in. With a wrapping burst starting
    // at the upper doubleword, the beat order is reversed relative to the line.
    function automatic logic beat_half(input logic beat_cnt, input logic start_hi);
        return beat_cnt ^ start_hi;
    endfunction

endpackage

// File: rtl/ysyx_22041752_refill.sv
// Cache-line refill sequencer: one miss -> one 2-beat 64-bit AXI read burst ->
// one 128-bit SRAM macro write -> one response pulse carrying the line.
// Optional build macro YSYX_22041752_REFILL_CWF_EN selects critical-word-first
// (WRAP burst starting at the missed doubleword); default is an aligned INCR burst.
module ysyx_22041752_refill
    import ysyx_22041752_refill_pkg::*;
#(
    parameter logic [3:0] ARID = 4'h0
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     req_valid,
    output logic                     req_ready,
    input  logic [31:0]              req_addr,
    input  logic [2:0]               req_way,
    output logic                     resp_valid,
    output logic                     resp_err,
    output logic [LINE_WD-1:0]       resp_line,
    output logic                     arvalid,
    input  logic                     arready,
    output logic [31:0]              araddr,
    output logic [3:0]               arid,
    output logic [7:0]               arlen,
    output logic [2:0]               arsize,
    output logic [1:0]               arburst,
    input  logic                     rvalid,
    output logic                     rready,
    input  logic [3:0]               rid,
    input  logic [BEAT_WD-1:0]       rdata,
    input  logic [1:0]               rresp,
    input  logic                     rlast,
    output logic [2:0]               sram_sel,
    output logic [SRAM_INDEX_WD-1:0] sram_addr,
    output logic                     sram_cen,
    output logic                     sram_wen,
    output logic [LINE_WD-1:0]       sram_wmask,
    output logic [LINE_WD-1:0]       sram_wdata
);

`ifdef YSYX_22041752_REFILL_CWF_EN
    localparam int         ADDR_LSB   = 3;
    localparam logic [1:0] BURST_TYPE = BURST_WRAP;
`else
    localparam int         ADDR_LSB   = 4;
    localparam logic [1:0] BURST_TYPE = BURST_INCR;
`endif

    refill_state_e        state_q, state_d;
    logic                 cnt_q, cnt_d;
    logic                 err_q, err_d;
    logic                 arvalid_q, arvalid_d;
    logic                 rready_q, rready_d;
    logic                 resp_valid_q, resp_valid_d;
    logic                 resp_err_q, resp_err_d;
    logic                 sram_wr_q, sram_wr_d;

    logic [31:ADDR_LSB]   addr_q, addr_d;
    logic [2:0]           way_q, way_d;
    logic [LINE_WD-1:0]   line_q, line_d;

    logic                 beat_fire;
    logic                 beat_bad;
    logic                 start_hi;
    logic                 unused_addr_bits;

    // Byte offset inside the burst start address never affects the request.
    assign unused_addr_bits = ^req_addr[ADDR_LSB-1:0];

`ifdef YSYX_22041752_REFILL_CWF_EN
    assign start_hi = addr_q[3];
`else
    assign start_hi = 1'b0;
`endif

    // Next-state, beat capture, error accumulation and next output values.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        err_d     = err_q;
        addr_d    = addr_q;
        way_d     = way_q;
        line_d    = line_q;

        // rready_q is high exactly while in R, so stray beats elsewhere never fire.
        beat_fire = rready_q & rvalid;
        // rlast must be low on beat 0 and high on beat 1, i.e. equal to the counter.
        beat_bad  = (rresp != 2'b00) || (rid != ARID) || (rlast != cnt_q);

        unique case (state_q)
            REFILL_IDLE: begin
                cnt_d = 1'b0;
                err_d = 1'b0;
                if (req_valid) begin
                    addr_d  = req_addr[31:ADDR_LSB];
                    way_d   = req_way;
                    state_d = REFILL_AR;
                end
            end
            REFILL_AR: begin
                if (arready) begin
                    state_d = REFILL_R;
                end
            end
            REFILL_R: begin
                if (beat_fire) begin
                    if (beat_half(cnt_q, start_hi)) begin
                        line_d[LINE_WD-1:BEAT_WD] = rdata;
                    end else begin
                        line_d[BEAT_WD-1:0] = rdata;
                    end
                    err_d = err_q | beat_bad;
                    cnt_d = ~cnt_q;
                    if (cnt_q) begin
                        state_d = err_d ? REFILL_RESP : REFILL_WR;
                    end
                end
            end
            REFILL_WR: begin
                state_d = REFILL_RESP;
            end
            REFILL_RESP: begin
                err_d   = 1'b0;
                state_d = REFILL_IDLE;
            end
            default: begin
                state_d = REFILL_IDLE;
            end
        endcase

        arvalid_d    = (state_d == REFILL_AR);
        rready_d     = (state_d == REFILL_R);
        sram_wr_d    = (state_d == REFILL_WR);
        resp_valid_d = (state_d == REFILL_RESP);
        resp_err_d   = (state_d == REFILL_RESP) & err_d;
    end

    // Control state and registered handshake/strobe outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= REFILL_IDLE;
            cnt_q        <= 1'b0;
            err_q        <= 1'b0;
            arvalid_q    <= 1'b0;
            rready_q     <= 1'b0;
            sram_wr_q    <= 1'b0;
            resp_valid_q <= 1'b0;
            resp_err_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            err_q        <= err_d;
            arvalid_q    <= arvalid_d;
            rready_q     <= rready_d;
            sram_wr_q    <= sram_wr_d;
            resp_valid_q <= resp_valid_d;
            resp_err_q   <= resp_err_d;
        end
    end

    // Request fields and line buffer; only meaningful when qualified by control.
    always_ff @(posedge clk) begin
        addr_q <= addr_d;
        way_q  <= way_d;
        line_q <= line_d;
    end

    assign req_ready  = (state_q == REFILL_IDLE);

    assign arvalid    = arvalid_q;
    assign araddr     = {addr_q, {ADDR_LSB{1'b0}}};
    assign arid       = ARID;
    assign arlen      = 8'd1;
    assign arsize     = 3'b011;
    assign arburst    = BURST_TYPE;
    assign rready     = rready_q;

    assign resp_valid = resp_valid_q;
    assign resp_err   = resp_err_q;
    assign resp_line  = line_q;

    assign sram_sel   = way_q;
    assign sram_addr  = addr_q[9:4];
    assign sram_cen   = ~sram_wr_q;
    assign sram_wen   = ~sram_wr_q;
    assign sram_wmask = {LINE_WD{~sram_wr_q}};
    assign sram_wdata = line_q;

endmodule

// File: tb/tb_ysyx_22041752_refill.sv
// Directed bench for the refill sequencer: a table of refill transactions with
// hand-computed outcomes, plus reset-state and reset-mid-burst sequences.
module tb_ysyx_22041752_refill;

    logic         clk = 1'b0;
    logic         reset;
    logic         req_valid;
    logic         req_ready;
    logic [31:0]  req_addr;
    logic [2:0]   req_way;
    logic         resp_valid;
    logic         resp_err;
    logic [127:0] resp_line;
    logic         arvalid;
    logic         arready;
    logic [31:0]  araddr;
    logic [3:0]   arid;
    logic [7:0]   arlen;
    logic [2:0]   arsize;
    logic [1:0]   arburst;
    logic         rvalid;
    logic         rready;
    logic [3:0]   rid;
    logic [63:0]  rdata;
    logic [1:0]   rresp;
    logic         rlast;
    logic [2:0]   sram_sel;
    logic [5:0]   sram_addr;
    logic         sram_cen;
    logic         sram_wen;
    logic [127:0] sram_wmask;
    logic [127:0] sram_wdata;

    int checks   = 0;
    int failures = 0;

`ifdef YSYX_22041752_REFILL_CWF_EN
    localparam logic [1:0] EXP_BURST = 2'b10;
`else
    localparam logic [1:0] EXP_BURST = 2'b01;
`endif

    always #5 clk = ~clk;

    ysyx_22041752_refill #(.ARID(4'h0)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_addr(req_addr), .req_way(req_way),
        .resp_valid(resp_valid), .resp_err(resp_err), .resp_line(resp_line),
        .arvalid(arvalid), .arready(arready), .araddr(araddr),
        .arid(arid), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .rvalid(rvalid), .rready(rready), .rid(rid), .rdata(rdata),
        .rresp(rresp), .rlast(rlast),
        .sram_sel(sram_sel), .sram_addr(sram_addr), .sram_cen(sram_cen),
        .sram_wen(sram_wen), .sram_wmask(sram_wmask), .sram_wdata(sram_wdata)
    );

    typedef struct {
        logic [31:0]  addr;
        logic [2:0]   way;
        int           ar_stall;
        int           r_gap;
        bit           stray;
        logic [63:0]  d0;
        logic [63:0]  d1;
        logic [1:0]   rresp0;
        logic [1:0]   rresp1;
        logic [3:0]   rid0;
        logic [3:0]   rid1;
        logic         rlast0;
        logic         rlast1;
        logic [31:0]  exp_araddr;
        logic [5:0]   exp_idx;
        logic [127:0] exp_line;
        logic         exp_err;
        int           exp_lat;
        int           exp_wr;
    } vec_t;

    vec_t vecs[9];

    task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, got, exp);
        end
    endtask

    task automatic check_int(input string name, input int got, input int exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic idle_inputs();
        req_valid = 1'b0;
        req_addr  = 32'h0;
        req_way   = 3'd0;
        arready   = 1'b0;
        rvalid    = 1'b0;
        rid       = 4'h0;
        rdata     = 64'h0;
        rresp     = 2'b00;
        rlast     = 1'b0;
    endtask

    task automatic run_vec(input int n, input vec_t v);
        int           cyc;
        int           stall;
        int           gap;
        int           beat;
        int           resp_cyc;
        int           wr_cyc;
        logic [127:0] got_line;
        logic         got_err;
        logic         rr_in_resp;
        logic         ar_bad;
        logic         wr_bad;
        logic         idle_bad;

        stall = v.ar_stall; gap = v.r_gap; beat = 0;
        resp_cyc = -1; wr_cyc = -1;
        got_line = '0; got_err = 1'b0; rr_in_resp = 1'b1;
        ar_bad = 1'b0; wr_bad = 1'b0; idle_bad = 1'b0;

        @(negedge clk);
        check($sformatf("v%0d req_ready_idle", n), 128'(req_ready), 128'(1'b1));
        req_addr  = v.addr;
        req_way   = v.way;
        req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        req_addr  = 32'hDEAD_BEEF;
        req_way   = ~v.way;
        cyc = 1;
        check($sformatf("v%0d arvalid_cycle1", n), 128'(arvalid), 128'(1'b1));

        while (resp_cyc < 0 && cyc < 40) begin
            arready = 1'b0; rvalid = 1'b0; rlast = 1'b0; rdata = 64'h0BAD_0BAD_0BAD_0BAD;
            rresp = 2'b00; rid = 4'h0;
            if (arvalid) begin
                if (araddr !== v.exp_araddr || arid !== 4'h0 || arlen !== 8'd1 ||
                    arsize !== 3'b011 || arburst !== EXP_BURST) ar_bad = 1'b1;
                if (stall > 0) begin
                    stall--;
                    if (v.stray) begin
                        rvalid = 1'b1; rlast = 1'b1; rdata = 64'hBAD0_BAD0_BAD0_BAD0;
                    end
                end else begin
                    arready = 1'b1;
                end
            end
            if (rready) begin
                if (gap > 0) begin
                    gap--;
                end else if (beat < 2) begin
                    rvalid = 1'b1;
                    rdata  = (beat == 0) ? v.d0 : v.d1;
                    rresp  = (beat == 0) ? v.rresp0 : v.rresp1;
                    rid    = (beat == 0) ? v.rid0 : v.rid1;
                    rlast  = (beat == 0) ? v.rlast0 : v.rlast1;
                    beat++;
                    gap = v.r_gap;
                end
            end
            if (sram_cen === 1'b0) begin
                wr_cyc = (wr_cyc < 0) ? cyc : -2;
                if (sram_wen !== 1'b0 || sram_wmask !== 128'h0 || sram_sel !== v.way ||
                    sram_addr !== v.exp_idx || sram_wdata !== v.exp_line) wr_bad = 1'b1;
            end else if (sram_wen !== 1'b1 || sram_wmask !== {128{1'b1}}) begin
                idle_bad = 1'b1;
            end
            if (resp_valid === 1'b1) begin
                resp_cyc   = cyc;
                got_err    = resp_err;
                got_line   = resp_line;
                rr_in_resp = req_ready;
            end else begin
                @(negedge clk);
                cyc++;
            end
        end
        idle_inputs();

        check_int($sformatf("v%0d resp_latency", n), resp_cyc, v.exp_lat);
        check($sformatf("v%0d resp_err", n), 128'(got_err), 128'(v.exp_err));
        if (!v.exp_err) check($sformatf("v%0d resp_line", n), got_line, v.exp_line);
        check_int($sformatf("v%0d wr_cycle", n), wr_cyc, v.exp_wr);
        check($sformatf("v%0d ar_fields", n), 128'(ar_bad), 128'(1'b0));
        check($sformatf("v%0d sram_wr_fields", n), 128'(wr_bad), 128'(1'b0));
        check($sformatf("v%0d sram_idle_levels", n), 128'(idle_bad), 128'(1'b0));
        check($sformatf("v%0d req_ready_in_resp", n), 128'(rr_in_resp), 128'(1'b0));
        @(negedge clk);
        check($sformatf("v%0d resp_pulse_end", n), 128'(resp_valid), 128'(1'b0));
        check($sformatf("v%0d req_ready_after", n), 128'(req_ready), 128'(1'b1));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        //          addr           way  stl gap str d0                      d1                      rr0    rr1    id0   id1   rl0   rl1   araddr         idx    line                                        err   lat wr
        vecs[0] = '{32'h8000_0120, 3'd3, 0, 0, 0, 64'hA,                  64'hB,                  2'b00, 2'b00, 4'h0, 4'h0, 1'b0, 1'b1, 32'h8000_0120, 6'h12, {64'hB, 64'hA},                           1'b0, 5,  4};
        vecs[1] = '{32'h1234_5670, 3'd7, 4, 0, 1, 64'h1111_1111_1111_1111, 64'h2222_2222_2222_2222, 2'b00, 2'b00, 4'h0, 4'h0, 1'b0, 1'b1, 32'h1234_5670, 6'h27, {64'h2222_2222_2222_2222, 64'h1111_1111_1111_1111}, 1'b0, 9, 8};
        vecs[2] = '{32'h0000_0040, 3'd0, 0, 0, 0, 64'h5,                  64'h6,                  2'b10, 2'b00, 4'h0, 4'h0, 1'b0, 1'b1, 32'h0000_0040, 6'h04, 128'h0,                                    1'b1, 4, -1};
        vecs[3] = '{32'h0000_0080, 3'd2, 0, 0, 0, 64'h7,                  64'h8,                  2'b00, 2'b00, 4'h0, 4'h0, 1'b1, 1'b1, 32'h0000_0080, 6'h08, 128'h0,                                    1'b1, 4, -1};
        vecs[4] = '{32'h0000_00C0, 3'd4, 0, 0, 0, 64'h9,                  64'hA,                  2'b00, 2'b00, 4'h0, 4'h0, 1'b0, 1'b0, 32'h0000_00C0, 6'h0C, 128'h0,                                    1'b1, 4, -1};
        vecs[5] = '{32'h0000_0100, 3'd1, 0, 0, 0, 64'hB,                  64'hC,                  2'b00, 2'b00, 4'h0, 4'h5, 1'b0, 1'b1, 32'h0000_0100, 6'h10, 128'h0,                                    1'b1, 4, -1};
        vecs[6] = '{32'h0000_03F0, 3'd6, 0, 0, 0, 64'hD,                  64'hE,                  2'b00, 2'b11, 4'h0, 4'h0, 1'b0, 1'b1, 32'h0000_03F0, 6'h3F, 128'h0,                                    1'b1, 4, -1};
        vecs[7] = '{32'hFFFF_FFF7, 3'd5, 0, 2, 0, 64'hFEED_0000_0000_0001, 64'hFEED_0000_0000_0002, 2'b00, 2'b00, 4'h0, 4'h0, 1'b0, 1'b1, 32'hFFFF_FFF0, 6'h3F, {64'hFEED_0000_0000_0002, 64'hFEED_0000_0000_0001}, 1'b0, 9, 8};
`ifdef YSYX_22041752_REFILL_CWF_EN
        vecs[8] = '{32'h8000_0128, 3'd1, 0, 0, 0, 64'hC,                  64'hD,                  2'b00, 2'b00, 4'h0, 4'h0, 1'b0, 1'b1, 32'h8000_0128, 6'h12, {64'hC, 64'hD},                           1'b0, 5,  4};
`else
        vecs[8] = '{32'h8000_0128, 3'd1, 0, 0, 0, 64'hC,                  64'hD,                  2'b00, 2'b00, 4'h0, 4'h0, 1'b0, 1'b1, 32'h8000_0120, 6'h12, {64'hD, 64'hC},                           1'b0, 5,  4};
`endif

        idle_inputs();
        reset = 1'b1;
        repeat (3) @(negedge clk);
        check("reset req_ready", 128'(req_ready), 128'(1'b1));
        check("reset arvalid", 128'(arvalid), 128'(1'b0));
        check("reset rready", 128'(rready), 128'(1'b0));
        check("reset resp_valid", 128'(resp_valid), 128'(1'b0));
        check("reset resp_err", 128'(resp_err), 128'(1'b0));
        check("reset sram_cen", 128'(sram_cen), 128'(1'b1));
        check("reset sram_wen", 128'(sram_wen), 128'(1'b1));
        reset = 1'b0;

        for (int i = 0; i < 9; i++) begin
            run_vec(i, vecs[i]);
        end

        // Reset asserted after beat 0 has landed abandons the burst.
        @(negedge clk);
        req_addr = 32'h0000_1000; req_way = 3'd2; req_valid = 1'b1;
        @(negedge clk);
        req_valid = 1'b0;
        check("mid arvalid", 128'(arvalid), 128'(1'b1));
        arready = 1'b1;
        @(negedge clk);
        arready = 1'b0;
        check("mid rready", 128'(rready), 128'(1'b1));
        rvalid = 1'b1; rdata = 64'h1234; rlast = 1'b0;
        @(negedge clk);
        rvalid = 1'b0;
        check("mid still_rready", 128'(rready), 128'(1'b1));
        reset = 1'b1;
        #1;
        check("mid async arvalid", 128'(arvalid), 128'(1'b0));
        check("mid async rready", 128'(rready), 128'(1'b0));
        @(posedge clk);
        #1;
        check("mid edge req_ready", 128'(req_ready), 128'(1'b1));
        check("mid edge arvalid", 128'(arvalid), 128'(1'b0));
        check("mid edge rready", 128'(rready), 128'(1'b0));
        check("mid edge sram_cen", 128'(sram_cen), 128'(1'b1));
        check("mid edge resp_valid", 128'(resp_valid), 128'(1'b0));
        @(negedge clk);
        reset = 1'b0;
        run_vec(9, vecs[0]);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
